// File: rtl/barrel_pkg.sv
// Shared definitions for the pipelined barrel shifters (left and right).
package barrel_pkg;

    localparam int DEFAULT_WIDTH   = 32;
    localparam int DEFAULT_SHAMT_W = $clog2(DEFAULT_WIDTH);

    // One pipeline stage entry at the default configuration. Parameterised
    // tops declare an identically shaped struct sized to their own WIDTH.
    typedef struct packed {
        logic                       valid;
        logic [DEFAULT_WIDTH-1:0]   data;
        logic [DEFAULT_SHAMT_W-1:0] amt;
        logic                       fill;
    } stage_entry_t;

    // Fill bit resolved once at acceptance: sign bit for arithmetic shifts,
    // the caller-supplied bit for logical shifts.
    function automatic logic fill_bit(input logic arith, input logic shift_in, input logic msb);
        return arith ? msb : shift_in;
    endfunction

endpackage

// File: rtl/barrel_shifter_right_pipe_shr_stage.sv
// Combinational conditional right shift by a fixed distance, vacated MSBs
// set to the fill bit. One instance per pipeline stage.
module shr_stage #(
    parameter int WIDTH = 32,
    parameter int DIST  = 1
) (
    input  logic [WIDTH-1:0] data_in,
    input  logic             shift_en,
    input  logic             fill,
    output logic [WIDTH-1:0] data_out
);

    logic [DIST-1:0] fill_bits;

    for (genvar gi = 0; gi < DIST; gi++) begin : g_fill
        assign fill_bits[gi] = fill;
    end

    assign data_out = shift_en ? {fill_bits, data_in[WIDTH-1:DIST]} : data_in;

endmodule

// File: rtl/barrel_shifter_right_pipe.sv
// Pipelined right barrel shifter. Stage k resolves amount bit SHAMT_W-1-k
// (MSB first); the last stage register is the output. Flow control is
// bubble-collapsing: a stage loads whenever it is empty or its content moves on.
module barrel_shifter_right_pipe
    import barrel_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               InValid,
    output logic               InReady,
    input  logic [WIDTH-1:0]   In,
    input  logic [SHAMT_W-1:0] ShiftAmount,
    input  logic               ShiftIn,
    input  logic               Arith,
    output logic               OutValid,
    input  logic               OutReady,
    output logic [WIDTH-1:0]   Out
);

    typedef struct packed {
        logic               valid;
        logic [WIDTH-1:0]   data;
        logic [SHAMT_W-1:0] amt;
        logic               fill;
    } entry_t;

    entry_t           stage_reg [SHAMT_W];
    entry_t           src       [SHAMT_W];
    logic [WIDTH-1:0] shifted   [SHAMT_W];
    logic [SHAMT_W-1:0] load;
    logic             in_fire;
    logic             unused_tail;

    // Ready chain: a stage may load if it is empty or its successor may load;
    // the output stage may load if empty or being drained.
    always_comb begin
        load[SHAMT_W-1] = !stage_reg[SHAMT_W-1].valid || OutReady;
        for (int k = SHAMT_W - 2; k >= 0; k--) begin
            load[k] = !stage_reg[k].valid || load[k+1];
        end
    end

    assign InReady = !Reset && load[0];
    assign in_fire = InValid && InReady;

    for (genvar gi = 0; gi < SHAMT_W; gi++) begin : g_stage
        if (gi == 0) begin : g_head
            assign src[gi] = {in_fire, In, ShiftAmount, fill_bit(Arith, ShiftIn, In[WIDTH-1])};
        end else begin : g_body
            assign src[gi] = stage_reg[gi-1];
        end

        shr_stage #(
            .WIDTH (WIDTH),
            .DIST  (1 << (SHAMT_W - 1 - gi))
        ) u_shr (
            .data_in  (src[gi].data),
            .shift_en (src[gi].amt[SHAMT_W-1-gi]),
            .fill     (src[gi].fill),
            .data_out (shifted[gi])
        );
    end

    // Stage registers: clear on reset, otherwise load the predecessor's
    // shifted entry when allowed; payload only updates for a real operation.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            for (int k = 0; k < SHAMT_W; k++) begin
                stage_reg[k] <= '0;
            end
        end else begin
            for (int k = 0; k < SHAMT_W; k++) begin
                if (load[k]) begin
                    stage_reg[k].valid <= src[k].valid;
                    if (src[k].valid) begin
                        stage_reg[k].data <= shifted[k];
                        stage_reg[k].amt  <= src[k].amt;
                        stage_reg[k].fill <= src[k].fill;
                    end
                end
            end
        end
    end

    assign OutValid = stage_reg[SHAMT_W-1].valid;
    assign Out      = stage_reg[SHAMT_W-1].data;

    // Amount and fill have no consumer after the final stage.
    assign unused_tail = ^{stage_reg[SHAMT_W-1].amt, stage_reg[SHAMT_W-1].fill};

endmodule

// File: tb/tb_barrel_shifter_right_pipe.sv
// Bench for barrel_shifter_right_pipe: directed shifts, latency, backpressure,
// mid-flight reset and a random stream against a arithmetic reference model.
module tb_barrel_shifter_right_pipe;

    localparam int W = 32;
    localparam int S = 5;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] din;
    logic [S-1:0] amt;
    logic         shift_in;
    logic         arith;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] dout;

    int n_vec = 0;
    int n_bad = 0;

    logic [W-1:0] exp_q [$];
    logic         in_xfer;
    logic         out_xfer;
    logic [W-1:0] last_out;
    logic         prev_stall = 1'b0;
    logic [W-1:0] held_out;
    logic         saw_full_block = 1'b0;

    always #5 clk = ~clk;

    barrel_shifter_right_pipe #(.WIDTH(W), .SHAMT_W(S)) dut (
        .Clock       (clk),
        .Reset       (rst),
        .InValid     (in_valid),
        .InReady     (in_ready),
        .In          (din),
        .ShiftAmount (amt),
        .ShiftIn     (shift_in),
        .Arith       (arith),
        .OutValid    (out_valid),
        .OutReady    (out_ready),
        .Out         (dout)
    );

    // Reference: shift a double-width word whose upper half is all fill bits.
    function automatic logic [W-1:0] ref_shift(input logic [W-1:0] d, input logic [S-1:0] a,
                                               input logic si, input logic ar);
        logic        f;
        logic [2*W-1:0] wide;
        f    = ar ? d[W-1] : si;
        wide = {{W{f}}, d};
        wide = wide >> a;
        return wide[W-1:0];
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // One clock: drive after the falling edge, sample 1ns later, score the
    // transfers that the next rising edge will perform.
    task automatic cycle(input logic r, input logic iv, input logic [W-1:0] d, input logic [S-1:0] a,
                         input logic si, input logic ar, input logic ordy);
        @(negedge clk);
        rst = r; in_valid = iv; din = d; amt = a; shift_in = si; arith = ar; out_ready = ordy;
        #1;
        in_xfer  = iv && in_ready;
        out_xfer = out_valid && ordy;
        last_out = dout;
        if (r) begin
            check("ready_in_reset", {31'b0, in_ready}, 32'd0);
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            check("in_ready", {31'b0, in_ready}, {31'b0, (exp_q.size() < S) || ordy});
            if (exp_q.size() == S && !ordy && !in_ready) saw_full_block = 1'b1;
            if (prev_stall) begin
                check("stall_valid", {31'b0, out_valid}, 32'd1);
                check("stall_hold", dout, held_out);
            end
            prev_stall = out_valid && !ordy;
            held_out   = dout;
            if (out_valid && exp_q.size() == 0) begin
                check("stale_out", {31'b0, out_valid}, 32'd0);
            end else if (out_xfer) begin
                check("result", dout, exp_q.pop_front());
            end
            if (in_xfer) exp_q.push_back(ref_shift(d, a, si, ar));
        end
        $display("t=%0t rst=%0b in=%0b/%0b %h>>%0d si=%0b ar=%0b out=%0b/%0b %h q=%0d",
                 $time, r, iv, in_ready, d, a, si, ar, out_valid, ordy, dout, exp_q.size());
    endtask

    task automatic directed(input string tag, input logic [W-1:0] d, input logic [S-1:0] a,
                            input logic si, input logic ar, input logic [W-1:0] expv);
        int  lat;
        logic got;
        cycle(1'b0, 1'b1, d, a, si, ar, 1'b1);
        check({tag, "_accept"}, {31'b0, in_xfer}, 32'd1);
        lat = 0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            lat++;
            cycle(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
            if (out_xfer) got = 1'b1;
        end
        check({tag, "_latency"}, lat, S);
        check({tag, "_value"}, last_out, expv);
    endtask

    logic [W-1:0] op_d  [8];
    logic [S-1:0] op_a  [8];
    logic         op_si [8];
    logic         op_ar [8];

    initial begin
        int idx;
        int cyc;

        // Reset state
        cycle(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        check("reset_out_valid", {31'b0, out_valid}, 32'd0);
        check("reset_out", dout, 32'd0);
        check("ready_after_reset", {31'b0, in_ready}, 32'd1);

        // Directed shifts with latency measurement
        directed("lsr31_zero", 32'h8000_0000, 5'd31, 1'b0, 1'b0, 32'h0000_0001);
        directed("asr4",       32'h8000_0000, 5'd4,  1'b0, 1'b1, 32'hF800_0000);
        directed("lsr8_ones",  32'h0000_00FF, 5'd8,  1'b1, 1'b0, 32'hFF00_0000);
        directed("shift0",     32'hDEAD_BEEF, 5'd0,  1'b0, 1'b1, 32'hDEAD_BEEF);

        // Backpressure: 8 back-to-back ops, output stalled for 6 cycles
        for (int i = 0; i < 8; i++) begin
            op_d[i]  = $urandom;
            op_a[i]  = S'($urandom_range(0, W - 1));
            op_si[i] = 1'($urandom_range(0, 1));
            op_ar[i] = 1'($urandom_range(0, 1));
        end
        idx = 0;
        cyc = 0;
        saw_full_block = 1'b0;
        while ((idx < 8 || exp_q.size() != 0) && cyc < 60) begin
            if (idx < 8)
                cycle(1'b0, 1'b1, op_d[idx], op_a[idx], op_si[idx], op_ar[idx], !(cyc >= 3 && cyc < 9));
            else
                cycle(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, !(cyc >= 3 && cyc < 9));
            if (in_xfer) idx++;
            cyc++;
        end
        check("bp_drained", exp_q.size(), 0);
        check("bp_full_block", {31'b0, saw_full_block}, 32'd1);

        // Reset with 3 operations in flight
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b1, $urandom, S'($urandom), 1'b1, 1'b0, 1'b1);
        end
        cycle(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        check("rst_flush_valid", {31'b0, out_valid}, 32'd0);
        check("rst_flush_out", dout, 32'd0);
        check("rst_ready", {31'b0, in_ready}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
            check("no_stale", {31'b0, out_valid}, 32'd0);
        end

        // Random stream with random valid and backpressure
        idx = 0;
        cyc = 0;
        while ((idx < 40 || exp_q.size() != 0) && cyc < 400) begin
            cycle(1'b0, (idx < 40) && ($urandom_range(0, 3) != 0), $urandom, S'($urandom),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 2) != 0);
            if (in_xfer) idx++;
            cyc++;
        end
        check("rand_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
